// File: rtl/clock_select_sequencer.sv
// Sequencer that drives the select of a glitchless clock mux: accepts one switch
// request at a time, holds the new select through a settle window, then enforces a dwell.
module clock_select_sequencer #(
    parameter int   SETTLE_CYCLES    = 8,
    parameter int   MIN_DWELL_CYCLES = 4,
    parameter logic RESET_SEL        = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_sel,
    output logic        req_ready,
    output logic        sel_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] switch_count
);

    // state  | meaning
    // IDLE   | waiting for a request; req_ready high
    // SETTLE | new select applied, waiting for the mux to settle; busy high
    // DWELL  | switch complete, holding off further requests
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2
    } state_t;

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] DWELL_LOAD  = (MIN_DWELL_CYCLES > 0) ? 16'(MIN_DWELL_CYCLES - 1) : 16'd0;

    state_t      state;
    logic [15:0] count;

    assign req_ready = (state == IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sel_out      <= RESET_SEL;
            busy         <= 1'b0;
            done         <= 1'b0;
            switch_count <= 16'd0;
            count        <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_sel != sel_out) begin
                            sel_out      <= req_sel;
                            switch_count <= switch_count + 16'd1;
                            count        <= SETTLE_LOAD;
                            busy         <= 1'b1;
                            state        <= SETTLE;
                        end else begin
                            // Request for the current select: acknowledge without settling.
                            done <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (count == 16'd0) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        if (MIN_DWELL_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            count <= DWELL_LOAD;
                            state <= DWELL;
                        end
                    end else begin
                        count <= count - 16'd1;
                    end
                end
                DWELL: begin
                    if (count == 16'd0) begin
                        state <= IDLE;
                    end else begin
                        count <= count - 16'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_select_sequencer.sv
// Scoreboard bench for clock_select_sequencer: stimulus pushes expected done events,
// a negedge monitor pops them; a second instance covers the zero-dwell and wrap cases.
module tb_clock_select_sequencer;

    typedef struct {
        int          cyc;
        logic        sel;
        logic [15:0] cnt;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_sel = 1'b0;
    logic        req_ready, sel_out, busy, done;
    logic [15:0] switch_count;
    logic        req_valid2 = 1'b0, req_sel2 = 1'b0;
    logic        req_ready2, sel_out2, busy2, done2;
    logic [15:0] switch_count2;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sb_q[$];

    clock_select_sequencer dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_sel(req_sel),
        .req_ready(req_ready), .sel_out(sel_out), .busy(busy), .done(done),
        .switch_count(switch_count)
    );

    clock_select_sequencer #(.SETTLE_CYCLES(1), .MIN_DWELL_CYCLES(0)) dut2 (
        .clock(clock), .reset(reset), .req_valid(req_valid2), .req_sel(req_sel2),
        .req_ready(req_ready2), .sel_out(sel_out2), .busy(busy2), .done(done2),
        .switch_count(switch_count2)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic s, input logic [15:0] n);
        exp_t e;
        e.cyc = c;
        e.sel = s;
        e.cnt = n;
        sb_q.push_back(e);
    endtask

    // Issue one request; returns #1 after the accepting edge with T = that edge's index.
    task automatic request(input logic s, output int t);
        @(negedge clock);
        req_valid = 1'b1;
        req_sel   = s;
        @(posedge clock);
        #1;
        t = cyc;
        req_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (done && busy) begin
                tests++;
                fails++;
                $display("FAIL done_busy_overlap: done=%0b busy=%0b (cycle %0d)", done, busy, cyc);
            end
            if (done) begin
                exp_t e;
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (e.cyc != cyc || e.sel != sel_out || e.cnt != switch_count) begin
                        fails++;
                        $display("FAIL done_event: got cyc=%0d sel=%0b cnt=%0d expected cyc=%0d sel=%0b cnt=%0d",
                                 cyc, sel_out, switch_count, e.cyc, e.sel, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        int t;
        #1;
        check("rst_sel_out", sel_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", switch_count, 0);
        check("rst_ready", req_ready, 1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("ready_after_release", req_ready, 1);

        // No-op request for the current select
        request(1'b0, t);
        push(t, 1'b0, 16'd0);
        check("noop_ready", req_ready, 1);
        check("noop_sel", sel_out, 0);

        // Real switch 0->1, with toggling requests held during settle/dwell
        request(1'b1, t);
        push(t + 8, 1'b1, 16'd1);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) begin
                @(posedge clock);
                #1;
            end
            check($sformatf("sw_busy_k%0d", k), busy, (k <= 7) ? 1 : 0);
            check($sformatf("sw_ready_k%0d", k), req_ready, (k >= 12) ? 1 : 0);
            check($sformatf("sw_sel_k%0d", k), sel_out, 1);
            check($sformatf("sw_cnt_k%0d", k), switch_count, 1);
            req_valid = (k < 11);
            req_sel   = k[0];
        end
        req_valid = 1'b0;

        // Three back-to-back no-ops followed immediately by a real switch 1->0
        @(negedge clock);
        req_valid = 1'b1;
        req_sel   = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clock);
            #1;
            push(cyc, 1'b1, 16'd1);
            check($sformatf("b2b_ready_%0d", j), req_ready, 1);
        end
        req_sel = 1'b0;
        @(posedge clock);
        #1;
        push(cyc + 8, 1'b0, 16'd2);
        req_valid = 1'b0;
        check("b2b_switch_sel", sel_out, 0);
        check("b2b_switch_cnt", switch_count, 2);
        repeat (13) @(posedge clock);
        #1;
        check("b2b_ready_end", req_ready, 1);

        // Reset three cycles into a settle: switch aborted, no done
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        request(1'b1, t);
        check("abort_sel_pre", sel_out, 1);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort_sel", sel_out, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_cnt", switch_count, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_ready", req_ready, 1);
        repeat (15) @(posedge clock);
        #1;
        check("abort_sel_after", sel_out, 0);

        // Zero-dwell instance: alternating requests held valid
        @(negedge clock);
        req_valid2 = 1'b1;
        req_sel2   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("fast_sel_%0d", i), sel_out2, (i % 2 == 0) ? 1 : 0);
            check($sformatf("fast_cnt_%0d", i), switch_count2, i + 1);
            check($sformatf("fast_busy_%0d", i), busy2, 1);
            req_sel2 = ~req_sel2;
            @(posedge clock);
            #1;
            check($sformatf("fast_done_%0d", i), done2, 1);
            check($sformatf("fast_busy_off_%0d", i), busy2, 0);
            check($sformatf("fast_ready_%0d", i), req_ready2, 1);
        end
        req_valid2 = 1'b0;

        // Counter wrap from preloaded 16'hFFFF
        @(negedge clock);
        force dut2.switch_count = 16'hFFFF;
        @(negedge clock);
        release dut2.switch_count;
        @(negedge clock);
        check("wrap_preload", switch_count2, 16'hFFFF);
        req_valid2 = 1'b1;
        req_sel2   = 1'b1;
        @(posedge clock);
        #1;
        req_valid2 = 1'b0;
        check("wrap_cnt", switch_count2, 0);
        check("wrap_sel", sel_out2, 1);

        repeat (4) @(posedge clock);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
